int_res_addr_seq: RTL

//  Streams the physical addresses of one strided vector access into the banked intermediate-result memory.

---
 rtl/int_res_addr_seq.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/int_res_addr_seq.sv
// Strided address streamer for the banked intermediate-result memory: flat base -> {bank, local}, then 1 or 2 beats per element.
// Optional bounds checking with err_o when ADDR_SEQ_BOUNDS_CHECK_EN is defined; otherwise addresses wrap modulo the memory size.
module int_res_addr_seq #(
  parameter int NUM_BANKS  = 4,
  parameter int BANK_DEPTH = 14336,
  parameter int MAX_LEN    = 64,
  parameter int ADDR_W     = $clog2(NUM_BANKS*BANK_DEPTH),
  parameter int STRIDE_W   = $clog2(BANK_DEPTH)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start_i,
  input  logic [ADDR_W-1:0]             base_addr_i,
  input  logic [$clog2(MAX_LEN+1)-1:0]  len_i,
  input  logic [STRIDE_W-1:0]           stride_i,
  input  logic                          width_i,
  output logic                          busy_o,
  output logic                          addr_valid_o,
  input  logic                          addr_ready_i,
  output logic [ADDR_W-1:0]             addr_o,
  output logic [$clog2(NUM_BANKS)-1:0]  bank_sel_o,
  output logic [$clog2(BANK_DEPTH)-1:0] bank_addr_o,
  output logic                          half_o,
  output logic                          last_o,
  output logic                          done_o
`ifdef ADDR_SEQ_BOUNDS_CHECK_EN
  ,
  output logic                          err_o
`endif
);

  localparam int LEN_W   = $clog2(MAX_LEN+1);
  localparam int BANK_W  = $clog2(NUM_BANKS);
  localparam int LOCAL_W = $clog2(BANK_DEPTH);
  localparam int BEAT_W  = $clog2(2*MAX_LEN+1);
  localparam int DCNT_W  = $clog2(NUM_BANKS+1);

  localparam logic [ADDR_W-1:0]  DEPTH_A   = ADDR_W'(BANK_DEPTH);
  localparam logic [LOCAL_W:0]   DEPTH_L   = (LOCAL_W+1)'(BANK_DEPTH);
  localparam logic [BANK_W-1:0]  LAST_BANK = BANK_W'(NUM_BANKS-1);
  localparam logic [DCNT_W-1:0]  DCNT_END  = DCNT_W'(NUM_BANKS-1);
  localparam logic               DOUBLE_W  = 1'b1;
  localparam logic               SECOND_H  = 1'b1;

  // IDLE: wait for start | DECOMP: reduce base to {bank,local} | STREAM: issue beats
  typedef enum logic [1:0] {ST_IDLE, ST_DECOMP, ST_STREAM} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [LEN_W-1:0]    r_len;
  logic [STRIDE_W-1:0] r_stride;
  logic                r_width;
  logic [ADDR_W-1:0]   r_red;
  logic [DCNT_W-1:0]   r_dcnt;
  logic [BANK_W-1:0]   r_ebank;
  logic [LOCAL_W-1:0]  r_elocal;
  logic [BANK_W-1:0]   r_bank;
  logic [LOCAL_W-1:0]  r_local;
  logic                r_half;
  logic [BEAT_W-1:0]   r_left;
  logic                r_done;

  logic                w_red_ge;
  logic [ADDR_W-1:0]   w_red_nxt;
  logic [BANK_W-1:0]   w_dbank_nxt;
  logic                w_decomp_end;
  logic                w_hs;
  logic                w_second;
  logic [LOCAL_W:0]    w_inc;
  logic [LOCAL_W:0]    w_sum;
  logic                w_sum_ge;
  logic                w_nwrap;
  logic [LOCAL_W-1:0]  w_nlocal;
  logic [BANK_W-1:0]   w_nbank;
  logic                w_finish;
  logic [ADDR_W-1:0]   w_addr;

`ifdef ADDR_SEQ_BOUNDS_CHECK_EN
  localparam logic [ADDR_W:0] TOTAL_A = (ADDR_W+1)'(NUM_BANKS*BANK_DEPTH);
  logic r_oor;
  logic r_err;
  logic w_err_set;
`endif

  // One conditional subtract per DECOMP cycle replaces a divider.
  assign w_red_ge     = (r_red >= DEPTH_A);
  assign w_red_nxt    = w_red_ge ? (r_red - DEPTH_A) : r_red;
  assign w_dbank_nxt  = !w_red_ge ? r_ebank :
                        (r_ebank == LAST_BANK) ? '0 : (r_ebank + BANK_W'(1));
  assign w_decomp_end = (r_state == ST_DECOMP) && (r_dcnt == DCNT_END);
  assign w_hs         = (r_state == ST_STREAM) && addr_ready_i;

  // Both the second half beat and the next element are offsets from the current element.
  assign w_second = (r_width == DOUBLE_W) && (r_half != SECOND_H);
  assign w_inc    = w_second ? (LOCAL_W+1)'(1) : (LOCAL_W+1)'(r_stride);
  assign w_sum    = {1'b0, r_elocal} + w_inc;
  assign w_sum_ge = (w_sum >= DEPTH_L);
  assign w_nlocal = w_sum_ge ? LOCAL_W'(w_sum - DEPTH_L) : LOCAL_W'(w_sum);
  assign w_nwrap  = w_sum_ge && (r_ebank == LAST_BANK);
  assign w_nbank  = !w_sum_ge ? r_ebank : (w_nwrap ? '0 : (r_ebank + BANK_W'(1)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_finish    = 1'b0;
`ifdef ADDR_SEQ_BOUNDS_CHECK_EN
    w_err_set   = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (start_i) w_state_nxt = ST_DECOMP;
      end
      ST_DECOMP: begin
        if (w_decomp_end) begin
          if (r_len == '0) begin
            w_state_nxt = ST_IDLE;
            w_finish    = 1'b1;
          end
`ifdef ADDR_SEQ_BOUNDS_CHECK_EN
          else if (r_oor) begin
            w_state_nxt = ST_IDLE;
            w_finish    = 1'b1;
            w_err_set   = 1'b1;
          end
`endif
          else begin
            w_state_nxt = ST_STREAM;
          end
        end
      end
      ST_STREAM: begin
        if (w_hs) begin
          if (r_left == BEAT_W'(1)) begin
            w_state_nxt = ST_IDLE;
            w_finish    = 1'b1;
          end
`ifdef ADDR_SEQ_BOUNDS_CHECK_EN
          else if (w_nwrap) begin
            w_state_nxt = ST_IDLE;
            w_finish    = 1'b1;
            w_err_set   = 1'b1;
          end
`endif
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_len    <= '0;
      r_stride <= '0;
      r_width  <= 1'b0;
      r_red    <= '0;
      r_dcnt   <= '0;
      r_ebank  <= '0;
      r_elocal <= '0;
      r_bank   <= '0;
      r_local  <= '0;
      r_half   <= 1'b0;
      r_left   <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= w_finish;
      case (r_state)
        ST_IDLE: begin
          if (start_i) begin
            r_len    <= len_i;
            r_stride <= stride_i;
            r_width  <= width_i;
            r_red    <= base_addr_i;
            r_dcnt   <= '0;
            r_ebank  <= '0;
          end
        end
        ST_DECOMP: begin
          r_red   <= w_red_nxt;
          r_ebank <= w_dbank_nxt;
          r_dcnt  <= r_dcnt + DCNT_W'(1);
          if (w_decomp_end) begin
            r_elocal <= LOCAL_W'(w_red_nxt);
            r_bank   <= w_dbank_nxt;
            r_local  <= LOCAL_W'(w_red_nxt);
            r_half   <= 1'b0;
            r_left   <= (r_width == DOUBLE_W) ? BEAT_W'({r_len, 1'b0}) : BEAT_W'(r_len);
          end
        end
        ST_STREAM: begin
          if (w_hs) begin
            r_left  <= r_left - BEAT_W'(1);
            r_bank  <= w_nbank;
            r_local <= w_nlocal;
            if (w_second) begin
              r_half <= 1'b1;
            end else begin
              r_ebank  <= w_nbank;
              r_elocal <= w_nlocal;
              r_half   <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ADDR_SEQ_BOUNDS_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_oor <= 1'b0;
      r_err <= 1'b0;
    end else if ((r_state == ST_IDLE) && start_i) begin
      r_oor <= ({1'b0, base_addr_i} >= TOTAL_A);
      r_err <= 1'b0;
    end else if (w_err_set) begin
      r_err <= 1'b1;
    end
  end

  assign err_o = r_err;
`endif

  assign w_addr = (ADDR_W'(r_bank) * DEPTH_A) + ADDR_W'(r_local);

  assign busy_o       = (r_state != ST_IDLE);
  assign addr_valid_o = (r_state == ST_STREAM);
  assign addr_o       = w_addr;
  assign bank_sel_o   = r_bank;
  assign bank_addr_o  = r_local;
  assign half_o       = r_half;
  assign last_o       = addr_valid_o && (r_left == BEAT_W'(1));
  assign done_o       = r_done;

endmodule
